// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared types and defaults for the VS-paced frame scheduler.
// Contents:
//   frame_sched_state_t : scheduler FSM states
//   *_DEF               : default SYNC_STAGES / FRAME_W / WDOG_CYCLES
//   DROP_MAX            : saturation value of the dropped-frame counter
//   drop_inc()          : saturating increment for the dropped-frame counter
package frame_sched_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    COMMIT    = 2'd1,
    TICK      = 2'd2,
    RUN       = 2'd3
  } frame_sched_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FRAME_W_DEF     = 16;
  localparam int WDOG_CYCLES_DEF = 2_000_000;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [7:0] drop_inc(input logic [7:0] cnt);
    return (cnt == DROP_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/frame_scheduler_vs_edge_sync.sv
// vs_edge_sync: brings the 25 MHz-domain VGA vertical sync into clk and
// produces a one-cycle strobe on its falling edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   vs_i       : raw vertical sync (active low)
//   edge_o     : one-cycle pulse, SYNC_STAGES+0 cycles after vs_i low is
//                first sampled (registered strobe)
// All flops reset to the "VS high" level so leaving reset never looks like
// a falling edge.
module vs_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      last_q <= 1'b1;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vs_i};
      last_q <= sync_q[SYNC_STAGES-1];
      // Registered so the strobe lands exactly SYNC_STAGES cycles after the
      // first low sample.
      edge_q <= last_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: paces game-logic updates and display-buffer commits from
// the VGA vertical sync. Each frame edge first commits the last completed
// game state (if any) and then starts the next update.
// Ports:
//   clk, rst_n  : 100 MHz clock, asynchronous active-low reset
//   vs          : VGA vertical sync (active low, foreign clock domain)
//   logic_done  : pulse, update started by tick has finished
//   ovr_clr     : pulse, clears overrun and drop_cnt
//   tick        : pulse, start one game update
//   commit      : pulse, load display buffer from game state
//   busy        : update in flight
//   frame_cnt   : wrapping count of frame edges (real or synthetic)
//   drop_cnt    : saturating count of frames lost to overrun
//   overrun     : sticky, set on any dropped frame
// Build option: define FRAME_SCHED_WDOG_EN to add a watchdog that generates
// a synthetic frame edge after WDOG_CYCLES cycles without a real one.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vs,
  input  logic               logic_done,
  input  logic               ovr_clr,
  output logic               tick,
  output logic               commit,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [7:0]         drop_cnt,
  output logic               overrun
);

  if (SYNC_STAGES < 2 || WDOG_CYCLES < 2) begin : g_bad_param
    $error("frame_scheduler: SYNC_STAGES and WDOG_CYCLES must be >= 2");
  end

  frame_sched_state_t state_q;
  logic               pending_q;
  logic               tick_q;
  logic               commit_q;
  logic               busy_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic [7:0]         drop_cnt_q;
  logic               overrun_q;
  logic               real_edge;
  logic               frame_edge;

  vs_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_vs_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .vs_i  (vs),
    .edge_o(real_edge)
  );

`ifdef FRAME_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_hit;

  assign wdog_hit = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  // Any real edge restarts the silence window; a hit restarts it too so
  // synthetic edges repeat every WDOG_CYCLES cycles while VS is absent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (real_edge || wdog_hit) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end
  end

  assign frame_edge = real_edge | wdog_hit;
`else
  assign frame_edge = real_edge;
`endif

  assign frame_cnt_d = frame_cnt_q + FRAME_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_EDGE;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      commit_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      tick_q   <= 1'b0;
      commit_q <= 1'b0;

      if (frame_edge) begin
        frame_cnt_q <= frame_cnt_d;
      end

      // A drop in the same cycle overrides this clear below.
      if (ovr_clr) begin
        drop_cnt_q <= '0;
        overrun_q  <= 1'b0;
      end

      case (state_q)
        WAIT_EDGE: begin
          if (frame_edge) begin
            if (pending_q) begin
              state_q  <= COMMIT;
              commit_q <= 1'b1;
            end else begin
              state_q <= TICK;
              tick_q  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          pending_q <= 1'b0;
          state_q   <= TICK;
          tick_q    <= 1'b1;
        end
        TICK: begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: begin
          if (logic_done) begin
            // Completion beats a coinciding edge: the edge then commits it.
            pending_q <= 1'b1;
            busy_q    <= 1'b0;
            if (frame_edge) begin
              state_q  <= COMMIT;
              commit_q <= 1'b1;
            end else begin
              state_q <= WAIT_EDGE;
            end
          end else if (frame_edge) begin
            drop_cnt_q <= ovr_clr ? 8'd1 : drop_inc(drop_cnt_q);
            overrun_q  <= 1'b1;
          end
        end
        default: state_q <= WAIT_EDGE;
      endcase
    end
  end

  assign tick      = tick_q;
  assign commit    = commit_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: scoreboard bench for frame_scheduler (SYNC_STAGES=2,
// FRAME_W=4, WDOG_CYCLES=1000). Expected tick/commit pulses are queued when a
// VS edge is driven and compared as the DUT emits them.
module tb_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs;
  logic       logic_done;
  logic       ovr_clr;
  logic       tick;
  logic       commit;
  logic       busy;
  logic [3:0] frame_cnt;
  logic [7:0] drop_cnt;
  logic       overrun;

  frame_scheduler #(
    .SYNC_STAGES(2),
    .FRAME_W    (4),
    .WDOG_CYCLES(1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vs        (vs),
    .logic_done(logic_done),
    .ovr_clr   (ovr_clr),
    .tick      (tick),
    .commit    (commit),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_commit;
    int cyc;
    int frame;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  bit   sb_en = 1'b1;

  int checks = 0;
  int errors = 0;

  // Abstract reference: idle/running, completed-but-uncommitted, counters.
  bit m_run, m_pending, m_overrun;
  int m_frames, m_drops;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && tick && commit) check_val("tick_commit_excl", 1, 0);
    if (sb_en && rst_n && (tick || commit)) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_pulse", {commit, tick}, 0);
      end else begin
        e = sb_q.pop_front();
        check_val("pulse_kind", commit, e.is_commit);
        check_val("pulse_cycle", cyc, e.cyc);
        check_val("pulse_frame", frame_cnt, e.frame);
        $display("txn %s cycle=%0d frame_cnt=%0d", e.is_commit ? "commit" : "tick", cyc, frame_cnt);
      end
    end
  end

  // One VS low pulse; optional logic_done / ovr_clr in the edge-strobe cycle.
  task automatic vs_edge(input bit with_done, input bit with_clr);
    int n;
    int t;
    @(negedge clk);
    vs = 1'b0;
    n  = cyc + 1;
    t  = -1;
    m_frames++;
    if (!m_run) begin
      if (with_clr) begin
        m_drops   = 0;
        m_overrun = 0;
      end
      if (m_pending) begin
        sb_q.push_back('{1'b1, n + 3, m_frames % 16});
        sb_q.push_back('{1'b0, n + 4, m_frames % 16});
        t = n + 4;
        m_pending = 0;
      end else begin
        sb_q.push_back('{1'b0, n + 3, m_frames % 16});
        t = n + 3;
      end
      m_run = 1;
    end else if (with_done) begin
      sb_q.push_back('{1'b1, n + 3, m_frames % 16});
      sb_q.push_back('{1'b0, n + 4, m_frames % 16});
      t = n + 4;
    end else begin
      m_drops   = with_clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      m_overrun = 1;
    end
    while (cyc < n + 2) @(negedge clk);
    logic_done = with_done;
    ovr_clr    = with_clr;
    @(negedge clk);
    logic_done = 1'b0;
    ovr_clr    = 1'b0;
    if (t > 0) begin
      while (cyc < t) @(negedge clk);
      check_val("busy_at_tick", busy, 0);
      @(negedge clk);
      check_val("busy_after_tick", busy, 1);
    end else begin
      check_val("busy_on_drop", busy, 1);
    end
    while (cyc < n + 10) @(negedge clk);
    vs = 1'b1;
    while (cyc < n + 30) @(negedge clk);
    check_val("frame_cnt", frame_cnt, m_frames % 16);
    check_val("drop_cnt", drop_cnt, m_drops);
    check_val("overrun", overrun, m_overrun);
  endtask

  task automatic done_pulse();
    @(negedge clk);
    logic_done = 1'b1;
    @(negedge clk);
    logic_done = 1'b0;
    if (m_run) begin
      m_run     = 0;
      m_pending = 1;
    end
    repeat (3) @(negedge clk);
    check_val("busy_after_done", busy, m_run);
  endtask

  task automatic model_reset();
    m_run     = 0;
    m_pending = 0;
    m_overrun = 0;
    m_frames  = 0;
    m_drops   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int nt;
    int last_commit;
    int done_at;
    int tick_cycles[$];

    vs = 1'b1; logic_done = 1'b0; ovr_clr = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_tick", tick, 0);
    check_val("rst_commit", commit, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_cnt", frame_cnt, 0);
    check_val("rst_drop_cnt", drop_cnt, 0);
    check_val("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // First edge: tick only, VS sampled low at cycle 100.
    while (cyc < 98) @(negedge clk);
    vs_edge(0, 0);

    // Completed update is committed on the next edge.
    while (cyc < 498) @(negedge clk);
    done_pulse();
    vs_edge(0, 0);

    // Three edges without completion: drops, then clear.
    for (int i = 0; i < 3; i++) vs_edge(0, 0);
    check_val("drop_cnt_3", drop_cnt, 3);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    m_drops = 0;
    m_overrun = 0;
    check_val("ovr_clr_drop_cnt", drop_cnt, 0);
    check_val("ovr_clr_overrun", overrun, 0);

    // Done coinciding with the edge strobe: commit then tick, no drop.
    vs_edge(1, 0);

    // Many drops: frame_cnt wraps, drop_cnt saturates at 255.
    for (int i = 0; i < 260; i++) vs_edge(0, 0);
    check_val("drop_cnt_sat", drop_cnt, 255);

    // Clear coinciding with a drop: the drop wins.
    vs_edge(0, 1);
    check_val("clr_vs_drop", drop_cnt, 1);

    // Reset while running abandons the update.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("midrun_rst_busy", busy, 0);
    check_val("midrun_rst_frame_cnt", frame_cnt, 0);
    check_val("midrun_rst_drop_cnt", drop_cnt, 0);
    check_val("midrun_rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_pulse();
    vs_edge(0, 0);

`ifdef FRAME_SCHED_WDOG_EN
    // VS held high: synthetic edges every WDOG_CYCLES keep updates going.
    done_pulse();
    sb_en       = 1'b0;
    last_commit = -10;
    done_at     = -1;
    for (int i = 0; i < 3500; i++) begin
      @(negedge clk);
      logic_done = (cyc == done_at);
      if (commit) last_commit = cyc;
      if (tick) begin
        check_val("wdog_commit_before_tick", last_commit, cyc - 1);
        tick_cycles.push_back(cyc);
        $display("txn wdog tick cycle=%0d", cyc);
        done_at = cyc + 5;
      end
    end
    logic_done = 1'b0;
    check_val("wdog_tick_count_ge3", (tick_cycles.size() >= 3), 1);
    for (int k = 1; k < tick_cycles.size(); k++)
      check_val("wdog_tick_period", tick_cycles[k] - tick_cycles[k-1], 1000);
    nt = 0;
    sb_en = 1'b1;
`else
    // VS held high without the watchdog: scheduler stalls.
    nt = 0;
    for (int i = 0; i < 3500; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    check_val("no_wdog_tick", nt, 0);
    check_val("stall_frame_cnt", frame_cnt, m_frames % 16);
    last_commit = 0;
    done_at = 0;
`endif

    check_val("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
